// File: rtl/d_merge_q.sv
// d_merge_q: load-return merge queue joining even/odd dcache bank lines into aligned, extended LSU results.
//
// Tracks up to DEPTH outstanding loads by OOO tag. Each entry waits for the bank line(s) it
// needs: the first bank only, or both banks for a line-crossing load. Once complete, the entry
// is presented on a valid/ready port to the LSU.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_alloc_*  / o_alloc_ready     new load to track (tag, byte address, size, signedness)
//   i_rsp_e_*, i_rsp_o_*           even/odd bank line responses (valid, tag, full line)
//   o_out_* / i_out_ready          merged result (valid, data, tag, address)
//   o_err_unmatched, o_err_tag     only with D_MERGE_Q_ERR_EN: sticky dropped-response flag and its tag
//
// Optional feature macro: D_MERGE_Q_ERR_EN
module d_merge_q #(
    parameter int CL_SIZE      = 128,
    parameter int OOO_TAG_SIZE = 10,
    parameter int DEPTH        = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_alloc_valid,
    output logic                    o_alloc_ready,
    input  logic [OOO_TAG_SIZE-1:0] i_alloc_tag,
    input  logic [31:0]             i_alloc_addr,
    input  logic [1:0]              i_alloc_size,
    input  logic                    i_alloc_signed,
    input  logic                    i_rsp_e_valid,
    input  logic [OOO_TAG_SIZE-1:0] i_rsp_e_tag,
    input  logic [CL_SIZE-1:0]      i_rsp_e_data,
    input  logic                    i_rsp_o_valid,
    input  logic [OOO_TAG_SIZE-1:0] i_rsp_o_tag,
    input  logic [CL_SIZE-1:0]      i_rsp_o_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [31:0]             o_out_data,
    output logic [OOO_TAG_SIZE-1:0] o_out_tag,
    output logic [31:0]             o_out_addr
`ifdef D_MERGE_Q_ERR_EN
    ,
    output logic                    o_err_unmatched,
    output logic [OOO_TAG_SIZE-1:0] o_err_tag
`endif
);
    localparam int LB  = CL_SIZE / 8;
    localparam int OFS = $clog2(LB);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic [1:0] {S_FREE, S_WAIT, S_DONE} state_t;

    state_t                  r_state  [DEPTH];
    logic [OOO_TAG_SIZE-1:0] r_tag    [DEPTH];
    logic [31:0]             r_addr   [DEPTH];
    logic [1:0]              r_size   [DEPTH];
    logic                    r_signed [DEPTH];
    logic                    r_split  [DEPTH];
    logic                    r_first  [DEPTH];
    logic [1:0]              r_have   [DEPTH];
    logic [CL_SIZE-1:0]      r_slot0  [DEPTH];
    logic [CL_SIZE-1:0]      r_slot1  [DEPTH];
    logic                    r_lock;
    logic [IW-1:0]           r_lock_idx;

    logic                    w_any_free;
    logic                    w_any_done;
    logic [IW-1:0]           w_free_idx;
    logic [IW-1:0]           w_done_idx;
    logic [IW-1:0]           w_sel;
    logic [DEPTH-1:0]        w_hit_e;
    logic [DEPTH-1:0]        w_hit_o;
    logic [1:0]              w_have_n [DEPTH];
    logic [OFS:0]            w_bytes;
    logic                    w_split;
    logic                    w_alloc;
    logic                    w_accept;
    logic [2*CL_SIZE-1:0]    w_full;
    logic [31:0]             w_sh;
    logic [31:0]             w_ext;

    // Lowest-index FREE and DONE entries; the descending loop leaves the lowest match.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_any_done = 1'b0;
        w_done_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_state[i] == S_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = IW'(i);
            end
            if (r_state[i] == S_DONE) begin
                w_any_done = 1'b1;
                w_done_idx = IW'(i);
            end
        end
    end

    assign w_bytes       = i_alloc_size == 2'd0 ? (OFS+1)'(1) : i_alloc_size == 2'd1 ? (OFS+1)'(2) : (OFS+1)'(4);
    assign w_split       = {1'b0, i_alloc_addr[OFS-1:0]} + w_bytes > (OFS+1)'(LB);
    assign w_alloc       = i_alloc_valid && w_any_free;
    assign o_alloc_ready = w_any_free;

    // Slot 0 holds the first bank's line, slot 1 the other bank's. An even response therefore
    // lands in slot r_first (0 when the load starts in the even bank), an odd one in slot ~r_first.
    // Only entries already in WAIT (allocated at an earlier edge) can match.
    always_comb begin
        w_hit_e = '0;
        w_hit_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit_e[i]  = i_rsp_e_valid && r_state[i] == S_WAIT && (!r_first[i] || r_split[i])
                          && !r_have[i][r_first[i]] && r_tag[i] == i_rsp_e_tag;
            w_hit_o[i]  = i_rsp_o_valid && r_state[i] == S_WAIT && (r_first[i] || r_split[i])
                          && !r_have[i][~r_first[i]] && r_tag[i] == i_rsp_o_tag;
            w_have_n[i] = r_have[i] | {(w_hit_e[i] && r_first[i]) || (w_hit_o[i] && !r_first[i]),
                                       (w_hit_e[i] && !r_first[i]) || (w_hit_o[i] && r_first[i])};
        end
    end

    // A locked entry keeps the port until accepted, so later DONE entries cannot preempt it.
    assign w_sel       = r_lock ? r_lock_idx : w_done_idx;
    assign o_out_valid = r_lock || w_any_done;
    assign w_accept    = o_out_valid && i_out_ready;

    assign w_full = {r_slot1[w_sel], r_slot0[w_sel]};
    assign w_sh   = 32'(w_full >> {r_addr[w_sel][OFS-1:0], 3'b000});

    always_comb begin
        w_ext = r_size[w_sel] == 2'd0 ? {{24{r_signed[w_sel] & w_sh[7]}}, w_sh[7:0]}
              : r_size[w_sel] == 2'd1 ? {{16{r_signed[w_sel] & w_sh[15]}}, w_sh[15:0]}
              : w_sh;
    end

    assign o_out_data = o_out_valid ? w_ext : '0;
    assign o_out_tag  = o_out_valid ? r_tag[w_sel] : '0;
    assign o_out_addr = o_out_valid ? r_addr[w_sel] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i]  <= S_FREE;
                r_tag[i]    <= '0;
                r_addr[i]   <= '0;
                r_size[i]   <= '0;
                r_signed[i] <= 1'b0;
                r_split[i]  <= 1'b0;
                r_first[i]  <= 1'b0;
                r_have[i]   <= '0;
                r_slot0[i]  <= '0;
                r_slot1[i]  <= '0;
            end
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot0[i] <= w_hit_e[i] && !r_first[i] ? i_rsp_e_data
                            : w_hit_o[i] && r_first[i] ? i_rsp_o_data : r_slot0[i];
                r_slot1[i] <= w_hit_e[i] && r_first[i] ? i_rsp_e_data
                            : w_hit_o[i] && !r_first[i] ? i_rsp_o_data : r_slot1[i];
                if (w_alloc && w_free_idx == IW'(i)) begin
                    r_state[i]  <= S_WAIT;
                    r_tag[i]    <= i_alloc_tag;
                    r_addr[i]   <= i_alloc_addr;
                    r_size[i]   <= i_alloc_size;
                    r_signed[i] <= i_alloc_signed;
                    r_split[i]  <= w_split;
                    r_first[i]  <= i_alloc_addr[OFS];
                    r_have[i]   <= '0;
                end else if (r_state[i] == S_WAIT) begin
                    r_have[i]  <= w_have_n[i];
                    r_state[i] <= w_have_n[i][0] && (w_have_n[i][1] || !r_split[i]) ? S_DONE : S_WAIT;
                end else if (r_state[i] == S_DONE && w_accept && w_sel == IW'(i)) begin
                    r_state[i] <= S_FREE;
                end
            end
            if (w_accept) begin
                r_lock <= 1'b0;
            end else if (o_out_valid && !r_lock) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_done_idx;
            end
        end
    end

`ifdef D_MERGE_Q_ERR_EN
    logic                    r_err;
    logic [OOO_TAG_SIZE-1:0] r_err_tag;
    logic                    w_drop_e;
    logic                    w_drop_o;

    assign w_drop_e = i_rsp_e_valid && !(|w_hit_e);
    assign w_drop_o = i_rsp_o_valid && !(|w_hit_o);

    // Even bank reports first when both responses are dropped together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err     <= 1'b0;
            r_err_tag <= '0;
        end else if (w_drop_e) begin
            r_err     <= 1'b1;
            r_err_tag <= i_rsp_e_tag;
        end else if (w_drop_o) begin
            r_err     <= 1'b1;
            r_err_tag <= i_rsp_o_tag;
        end
    end

    assign o_err_unmatched = r_err;
    assign o_err_tag       = r_err_tag;
`endif
endmodule

// File: tb/tb_d_merge_q.sv
// tb_d_merge_q: directed and randomized checks of d_merge_q against a byte-level reference model.
module tb_d_merge_q;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         i_rst_n;
    logic         i_alloc_valid;
    logic         o_alloc_ready;
    logic [9:0]   i_alloc_tag;
    logic [31:0]  i_alloc_addr;
    logic [1:0]   i_alloc_size;
    logic         i_alloc_signed;
    logic         i_rsp_e_valid;
    logic [9:0]   i_rsp_e_tag;
    logic [127:0] i_rsp_e_data;
    logic         i_rsp_o_valid;
    logic [9:0]   i_rsp_o_tag;
    logic [127:0] i_rsp_o_data;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [31:0]  o_out_data;
    logic [9:0]   o_out_tag;
    logic [31:0]  o_out_addr;
`ifdef D_MERGE_Q_ERR_EN
    logic         o_err_unmatched;
    logic [9:0]   o_err_tag;
`endif

    always #5 clk = ~clk;

    d_merge_q dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready), .i_alloc_tag(i_alloc_tag),
        .i_alloc_addr(i_alloc_addr), .i_alloc_size(i_alloc_size), .i_alloc_signed(i_alloc_signed),
        .i_rsp_e_valid(i_rsp_e_valid), .i_rsp_e_tag(i_rsp_e_tag), .i_rsp_e_data(i_rsp_e_data),
        .i_rsp_o_valid(i_rsp_o_valid), .i_rsp_o_tag(i_rsp_o_tag), .i_rsp_o_data(i_rsp_o_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_tag(o_out_tag), .o_out_addr(o_out_addr)
`ifdef D_MERGE_Q_ERR_EN
        , .o_err_unmatched(o_err_unmatched), .o_err_tag(o_err_tag)
`endif
    );

    int total = 0;
    int bad   = 0;

    bit           m_live [DEPTH];
    bit           m_done [DEPTH];
    bit           m_ne   [DEPTH];
    bit           m_no   [DEPTH];
    bit           m_ge   [DEPTH];
    bit           m_go   [DEPTH];
    bit           m_sgn  [DEPTH];
    logic [9:0]   m_tag  [DEPTH];
    logic [31:0]  m_addr [DEPTH];
    logic [1:0]   m_size [DEPTH];
    logic [127:0] m_le   [DEPTH];
    logic [127:0] m_lo   [DEPTH];
    bit           m_lock;
    int           m_lidx;
    bit           m_err;
    logic [9:0]   m_etag;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Gather the load's bytes one at a time from the first-bank line, spilling into the other line.
    function automatic logic [31:0] form(logic [31:0] a, logic [1:0] sz, bit sg, logic [127:0] le, logic [127:0] lo);
        logic [127:0] f;
        logic [127:0] s;
        logic [31:0]  r;
        int ofs, nb, p;
        f   = a[4] ? lo : le;
        s   = a[4] ? le : lo;
        ofs = int'(a[3:0]);
        nb  = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        r   = '0;
        for (int k = 0; k < nb; k++) begin
            p = ofs + k;
            r[8*k +: 8] = p < 16 ? f[8*p +: 8] : s[8*(p-16) +: 8];
        end
        if (sg && r[8*nb-1])
            for (int k = nb; k < 4; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic int m_sel();
        if (m_lock) return m_lidx;
        for (int i = 0; i < DEPTH; i++) if (m_done[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_live[i] = 0; m_done[i] = 0; m_ge[i] = 0; m_go[i] = 0;
        end
        m_lock = 0; m_lidx = 0; m_err = 0; m_etag = '0;
    endtask

    task automatic m_update(input int s, input bit rdy);
        int a, ofs, nb;
        bit he, ho;
        a = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_live[i]) a = i;
        he = 0; ho = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_live[i] && !m_done[i]) begin
                if (i_rsp_e_valid && m_ne[i] && !m_ge[i] && m_tag[i] == i_rsp_e_tag) begin
                    m_ge[i] = 1; m_le[i] = i_rsp_e_data; he = 1;
                end
                if (i_rsp_o_valid && m_no[i] && !m_go[i] && m_tag[i] == i_rsp_o_tag) begin
                    m_go[i] = 1; m_lo[i] = i_rsp_o_data; ho = 1;
                end
                if ((!m_ne[i] || m_ge[i]) && (!m_no[i] || m_go[i])) m_done[i] = 1;
            end
        end
        if (s >= 0 && i_out_ready) begin
            m_live[s] = 0; m_done[s] = 0; m_lock = 0;
        end else if (s >= 0) begin
            m_lock = 1; m_lidx = s;
        end
        if (i_rsp_e_valid && !he) begin
            m_err = 1; m_etag = i_rsp_e_tag;
        end else if (i_rsp_o_valid && !ho) begin
            m_err = 1; m_etag = i_rsp_o_tag;
        end
        if (i_alloc_valid && rdy && a >= 0) begin
            ofs = int'(i_alloc_addr[3:0]);
            nb  = i_alloc_size == 2'd0 ? 1 : i_alloc_size == 2'd1 ? 2 : 4;
            m_live[a] = 1; m_done[a] = 0; m_ge[a] = 0; m_go[a] = 0;
            m_tag[a] = i_alloc_tag; m_addr[a] = i_alloc_addr; m_size[a] = i_alloc_size; m_sgn[a] = i_alloc_signed;
            m_ne[a] = !i_alloc_addr[4] || ofs + nb > 16;
            m_no[a] = i_alloc_addr[4] || ofs + nb > 16;
        end
    endtask

    // Compare outputs against the model, take one clock edge with the held inputs, advance the model.
    task automatic tick();
        int s;
        bit rdy;
        rdy = 0;
        for (int i = 0; i < DEPTH; i++) if (!m_live[i]) rdy = 1;
        s = m_sel();
        chk("alloc_ready", o_alloc_ready, rdy);
        chk("out_valid", o_out_valid, s >= 0);
        if (s >= 0) begin
            chk("out_tag", o_out_tag, m_tag[s]);
            chk("out_addr", o_out_addr, m_addr[s]);
            chk("out_data", o_out_data, form(m_addr[s], m_size[s], m_sgn[s], m_le[s], m_lo[s]));
        end
`ifdef D_MERGE_Q_ERR_EN
        chk("err_unmatched", o_err_unmatched, m_err);
        chk("err_tag", o_err_tag, m_etag);
`endif
        @(posedge clk);
        #1;
        m_update(s, rdy);
    endtask

    task automatic idle_in();
        i_alloc_valid = 0; i_alloc_tag = '0; i_alloc_addr = '0; i_alloc_size = '0; i_alloc_signed = 0;
        i_rsp_e_valid = 0; i_rsp_e_tag = '0; i_rsp_e_data = '0;
        i_rsp_o_valid = 0; i_rsp_o_tag = '0; i_rsp_o_data = '0;
        i_out_ready = 0;
    endtask

    task automatic set_alloc(input logic [9:0] t, input logic [31:0] a, input logic [1:0] sz, input bit sg);
        i_alloc_valid = 1; i_alloc_tag = t; i_alloc_addr = a; i_alloc_size = sz; i_alloc_signed = sg;
    endtask

    task automatic set_e(input logic [9:0] t, input logic [127:0] d);
        i_rsp_e_valid = 1; i_rsp_e_tag = t; i_rsp_e_data = d;
    endtask

    task automatic set_o(input logic [9:0] t, input logic [127:0] d);
        i_rsp_o_valid = 1; i_rsp_o_tag = t; i_rsp_o_data = d;
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int k;
        bit clash;
        idle_in();
        i_rst_n = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset alloc_ready", o_alloc_ready, 1);
        chk("reset out_valid", o_out_valid, 0);
        chk("reset out_data", o_out_data, 0);
        chk("reset out_tag", o_out_tag, 0);
        chk("reset out_addr", o_out_addr, 0);
        i_rst_n = 1;
        // aligned word in the even line
        set_alloc(10'd5, 32'h104, 2'd2, 0); tick(); idle_in();
        set_e(10'd5, 128'h89ABCDEF << 32); tick(); idle_in();
        chk("t1 valid", o_out_valid, 1);
        chk("t1 data", o_out_data, 32'h89ABCDEF);
        chk("t1 tag", o_out_tag, 5);
        i_out_ready = 1; tick(); idle_in();
        // line-crossing word starting in the odd bank, odd line arrives first
        set_alloc(10'd6, 32'h11E, 2'd2, 1); tick(); idle_in();
        set_o(10'd6, 128'h1122 << 112); tick(); idle_in();
        chk("t2 wait", o_out_valid, 0);
        tick();
        set_e(10'd6, 128'h3344); tick(); idle_in();
        chk("t2 valid", o_out_valid, 1);
        chk("t2 data", o_out_data, 32'h33441122);
        i_out_ready = 1; tick(); idle_in();
        // byte sign/zero extension
        set_alloc(10'd7, 32'h3, 2'd0, 1); tick(); idle_in();
        set_e(10'd7, 128'h80 << 24); tick(); idle_in();
        chk("t3 signed", o_out_data, 32'hFFFFFF80);
        i_out_ready = 1; tick(); idle_in();
        set_alloc(10'd8, 32'h3, 2'd0, 0); tick(); idle_in();
        set_e(10'd8, 128'h80 << 24); tick(); idle_in();
        chk("t3 unsigned", o_out_data, 32'h00000080);
        i_out_ready = 1; tick(); idle_in();
        // full queue, lock holds against a lower DONE entry
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(10'(20 + i), 32'h40 * i, 2'd2, 0); tick(); idle_in();
        end
        chk("t4 full", o_alloc_ready, 0);
        set_alloc(10'd30, 32'h0, 2'd2, 0); tick(); idle_in();
        set_e(10'd22, rnd_line()); tick(); idle_in();
        set_e(10'd20, rnd_line()); tick(); idle_in();
        chk("t4 lock tag", o_out_tag, 22);
        tick();
        chk("t4 hold tag", o_out_tag, 22);
        i_out_ready = 1; tick();
        chk("t4 next tag", o_out_tag, 20);
        chk("t4 freed", o_alloc_ready, 1);
        set_e(10'd21, rnd_line()); tick(); i_rsp_e_valid = 0;
        set_e(10'd23, rnd_line()); tick(); i_rsp_e_valid = 0;
        tick(); tick(); idle_in();
        // unmatched response
        set_e(10'd9, rnd_line()); tick(); idle_in();
        chk("t5 valid", o_out_valid, 0);
`ifdef D_MERGE_Q_ERR_EN
        chk("t5 err", o_err_unmatched, 1);
        chk("t5 err_tag", o_err_tag, 9);
`endif
        tick();
        // asynchronous reset mid-operation
        set_alloc(10'd40, 32'h0, 2'd2, 0); tick();
        set_alloc(10'd41, 32'h10, 2'd2, 0); tick(); idle_in();
        set_e(10'd40, rnd_line()); tick(); idle_in();
        chk("t6 pre valid", o_out_valid, 1);
        #2 i_rst_n = 0;
        #1;
        chk("t6 rst valid", o_out_valid, 0);
        chk("t6 rst data", o_out_data, 0);
        m_reset();
        @(posedge clk);
        #1 i_rst_n = 1;
        set_o(10'd41, rnd_line()); tick(); idle_in();
        chk("t6 stale", o_out_valid, 0);
        tick();
        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            i_alloc_valid  = 1'($urandom_range(0, 1));
            i_alloc_tag    = 10'($urandom_range(0, 511));
            i_alloc_addr   = $urandom;
            i_alloc_size   = 2'($urandom_range(0, 3));
            i_alloc_signed = 1'($urandom_range(0, 1));
            clash = 0;
            for (int i = 0; i < DEPTH; i++) if (m_live[i] && m_tag[i] == i_alloc_tag) clash = 1;
            if (clash) i_alloc_valid = 0;
            k = $urandom_range(0, DEPTH - 1);
            i_rsp_e_valid = $urandom_range(0, 9) < 6;
            i_rsp_e_tag   = m_live[k] && $urandom_range(0, 7) != 0 ? m_tag[k] : 10'(512 + $urandom_range(0, 511));
            i_rsp_e_data  = rnd_line();
            k = $urandom_range(0, DEPTH - 1);
            i_rsp_o_valid = $urandom_range(0, 9) < 6;
            i_rsp_o_tag   = m_live[k] && $urandom_range(0, 7) != 0 ? m_tag[k] : 10'(512 + $urandom_range(0, 511));
            i_rsp_o_data  = rnd_line();
            i_out_ready   = $urandom_range(0, 2) != 0;
            tick();
        end
        idle_in();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
